// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic-cycle master adapter:
// the state encoding, the reset level and a zero word wide enough for any data width.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUSY = 2'd1,
        WB_HOLD = 2'd2
    } wb_state_t;

    localparam logic WB_RST_ACTIVE = 1'b0;

    // Sliced down to DW by each user; DW above this is not supported.
    localparam int WB_MAX_DW = 512;
    localparam logic [WB_MAX_DW-1:0] WB_ZERO_WORD = '0;

endpackage

// File: rtl/wb_master_if_watchdog.sv
// Saturating BUSY-cycle counter; o_expired is high once LIMIT cycles have been counted.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst == WB_RST_ACTIVE) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT_C);

endmodule

// File: rtl/wb_master_if.sv
// Wishbone classic-cycle master adapter for one CPU pipeline port (fetch or memory),
// with bus-error handling, an optional watchdog and a captured fault address.
module wb_master_if
    import wb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int STALL_W = 6,
    parameter int STAGE   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [DW/8-1:0]    cpu_sel_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [DW-1:0]      cpu_data_i,
    output logic [DW-1:0]      cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    output logic [AW-1:0]      bus_err_addr_o,
    input  logic [DW-1:0]      wishbone_data_i,
    input  logic               wishbone_ack_i,
    input  logic               wishbone_err_i,
    output logic [AW-1:0]      wishbone_addr_o,
    output logic [DW-1:0]      wishbone_data_o,
    output logic               wishbone_we_o,
    output logic [DW/8-1:0]    wishbone_sel_o,
    output logic               wishbone_stb_o,
    output logic               wishbone_cyc_o
);

    localparam logic [DW-1:0] ZERO = WB_ZERO_WORD[DW-1:0];

    wb_state_t        r_state;
    wb_state_t        w_state_next;
    logic [AW-1:0]    r_wb_addr;
    logic [DW-1:0]    r_wb_data;
    logic             r_wb_we;
    logic [DW/8-1:0]  r_wb_sel;
    logic             r_wb_stb;
    logic             r_wb_cyc;
    logic [AW-1:0]    r_err_addr;
    logic [DW-1:0]    r_rbuf;

    logic             w_in_reset;
    logic             w_stalled;
    logic             w_accept;
    logic             w_fault;
    logic             w_ack_done;
    logic             w_expired;
    logic             w_wd_enable;
    logic             w_stallreq;
    logic [DW-1:0]    w_cpu_data;
    logic [DW-1:0]    w_rbuf_next;

    assign w_in_reset  = (rst == WB_RST_ACTIVE);
    // Any stall bit holds the result; the consuming stage's own bit is always part of that.
    assign w_stalled   = (|stall_i) | stall_i[STAGE];
    assign w_wd_enable = (r_state == WB_BUSY);

    generate
        if (TIMEOUT > 0) begin : g_watchdog
            wb_watchdog #(
                .LIMIT(TIMEOUT)
            ) u_watchdog (
                .clk       (clk),
                .rst       (rst),
                .i_clear   (w_accept),
                .i_enable  (w_wd_enable),
                .o_expired (w_expired)
            );
        end else begin : g_no_watchdog
            assign w_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_fault      = 1'b0;
        w_ack_done   = 1'b0;
        w_stallreq   = 1'b0;
        w_cpu_data   = ZERO;
        w_rbuf_next  = ZERO;
        case (r_state)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    w_stallreq   = 1'b1;
                    w_accept     = 1'b1;
                    w_state_next = WB_BUSY;
                end
            end
            WB_BUSY: begin
                // Priority: flush, then err, then watchdog, then ack.
                if (flush_i) begin
                    w_state_next = WB_IDLE;
                end else if (wishbone_err_i || w_expired) begin
                    w_fault      = 1'b1;
                    w_state_next = w_stalled ? WB_HOLD : WB_IDLE;
                end else if (wishbone_ack_i) begin
                    w_ack_done   = 1'b1;
                    w_rbuf_next  = r_wb_we ? ZERO : wishbone_data_i;
                    w_cpu_data   = w_rbuf_next;
                    w_state_next = w_stalled ? WB_HOLD : WB_IDLE;
                end else begin
                    w_stallreq = 1'b1;
                end
            end
            WB_HOLD: begin
                w_cpu_data = r_rbuf;
                if (!w_stalled || flush_i) begin
                    w_state_next = WB_IDLE;
                end
            end
            default: begin
                w_state_next = WB_IDLE;
            end
        endcase
        if (w_in_reset) begin
            w_stallreq = 1'b0;
            w_cpu_data = ZERO;
            w_fault    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            r_state    <= WB_IDLE;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wb_we    <= 1'b0;
            r_wb_sel   <= '0;
            r_wb_stb   <= 1'b0;
            r_wb_cyc   <= 1'b0;
            r_err_addr <= '0;
            r_rbuf     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_wb_addr <= cpu_addr_i;
                r_wb_data <= cpu_data_i;
                r_wb_we   <= cpu_we_i;
                r_wb_sel  <= cpu_sel_i;
                r_wb_stb  <= 1'b1;
                r_wb_cyc  <= 1'b1;
            end else if ((r_state == WB_BUSY) && (w_state_next != WB_BUSY)) begin
                r_wb_stb <= 1'b0;
                r_wb_cyc <= 1'b0;
            end
            if (w_fault) begin
                r_err_addr <= r_wb_addr;
                r_rbuf     <= '0;
            end else if (w_ack_done) begin
                r_rbuf <= w_rbuf_next;
            end
        end
    end

    assign cpu_data_o      = w_cpu_data;
    assign stallreq_o      = w_stallreq;
    assign bus_err_o       = w_fault;
    assign bus_err_addr_o  = r_err_addr;
    assign wishbone_addr_o = r_wb_addr;
    assign wishbone_data_o = r_wb_data;
    assign wishbone_we_o   = r_wb_we;
    assign wishbone_sel_o  = r_wb_sel;
    assign wishbone_stb_o  = r_wb_stb;
    assign wishbone_cyc_o  = r_wb_cyc;

endmodule

// File: tb/tb_wb_master_if.sv
// Bench for wb_master_if (DW=64, TIMEOUT=4): directed transaction table, randomized
// transactions against a transaction-level model, and a reset-while-busy sequence.
module tb_wb_master_if;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = 6;
    localparam int TO = 4;
    localparam int NONE = 99;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   stall;
    logic            flush;
    logic            ce;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   cpu_data;
    logic            stallreq;
    logic            bus_err;
    logic [AW-1:0]   bus_err_addr;
    logic [DW-1:0]   wb_rdata;
    logic            wb_ack;
    logic            wb_err;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_wdata;
    logic            wb_we;
    logic [DW/8-1:0] wb_sel;
    logic            wb_stb;
    logic            wb_cyc;

    always #5 clk = ~clk;

    wb_master_if #(
        .DW(DW), .AW(AW), .STALL_W(SW), .STAGE(0), .TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .cpu_ce_i        (ce),
        .cpu_we_i        (we),
        .cpu_sel_i       (sel),
        .cpu_addr_i      (addr),
        .cpu_data_i      (wdata),
        .cpu_data_o      (cpu_data),
        .stallreq_o      (stallreq),
        .bus_err_o       (bus_err),
        .bus_err_addr_o  (bus_err_addr),
        .wishbone_data_i (wb_rdata),
        .wishbone_ack_i  (wb_ack),
        .wishbone_err_i  (wb_err),
        .wishbone_addr_o (wb_addr),
        .wishbone_data_o (wb_wdata),
        .wishbone_we_o   (wb_we),
        .wishbone_sel_o  (wb_sel),
        .wishbone_stb_o  (wb_stb),
        .wishbone_cyc_o  (wb_cyc)
    );

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW/8-1:0] sel;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   rdata;
        int              resp;      // BUSY cycle index of slave response, NONE = silent
        logic            err;       // response is an error (ack asserted too)
        int              flush_at;  // BUSY cycle index of flush, NONE = no flush
        int              hold;      // HOLD cycles requested after completion
        int              exp_end;   // expected terminating BUSY cycle index
        int              exp_kind;  // 0 ack, 1 error/timeout, 2 flush
        logic [DW-1:0]   exp_data;  // data presented to the pipeline on completion
    } txn_t;

    int            n_pass = 0;
    int            n_total = 0;
    logic [AW-1:0] m_err_addr;
    txn_t          table_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [7:0] s,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                input int rsp, input logic e, input int fl, input int h,
                                input int xe, input int xk, input logic [DW-1:0] xd);
        txn_t t;
        t.we = w; t.addr = a; t.sel = s; t.wdata = wd; t.rdata = rd;
        t.resp = rsp; t.err = e; t.flush_at = fl; t.hold = h;
        t.exp_end = xe; t.exp_kind = xk; t.exp_data = xd;
        return t;
    endfunction

    // Walk the BUSY cycles and apply the termination rules in priority order.
    function automatic void predict(inout txn_t t);
        t.exp_kind = -1;
        t.exp_end = 0;
        for (int i = 0; i <= TO && t.exp_kind < 0; i++) begin
            if (i == t.flush_at) t.exp_kind = 2;
            else if (i == t.resp && t.err) t.exp_kind = 1;
            else if (i == TO) t.exp_kind = 1;
            else if (i == t.resp) t.exp_kind = 0;
            if (t.exp_kind >= 0) t.exp_end = i;
        end
        t.exp_data = (t.exp_kind == 0 && !t.we) ? t.rdata : '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        logic [SW-1:0] sv;
        if (t.hold > 0) sv = (idx < 100) ? 6'b000011 : 6'($urandom_range(1, 63));
        else sv = '0;
        ce = 1'b1; we = t.we; addr = t.addr; sel = t.sel; wdata = t.wdata;
        flush = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; stall = '0;
        @(negedge clk);
        chk("req_stallreq", stallreq, 1);
        chk("req_cyc", wb_cyc, 0);
        chk("req_bus_err", bus_err, 0);
        chk("req_err_addr", bus_err_addr, m_err_addr);
        step();
        ce = 1'b0; addr = $urandom; wdata = {$urandom, $urandom}; sel = 8'($urandom); we = 1'($urandom);
        for (int i = 0; i <= t.exp_end; i++) begin
            wb_ack = (i == t.resp);
            wb_err = (i == t.resp) && t.err;
            flush = (i == t.flush_at);
            stall = sv;
            wb_rdata = (i == t.resp) ? t.rdata : {$urandom, $urandom};
            @(negedge clk);
            chk("busy_cyc", wb_cyc, 1);
            chk("busy_stb", wb_stb, 1);
            chk("busy_addr", wb_addr, t.addr);
            chk("busy_we", wb_we, t.we);
            chk("busy_sel", wb_sel, t.sel);
            chk("busy_wdata", wb_wdata, t.wdata);
            chk("busy_err_addr", bus_err_addr, m_err_addr);
            if (i < t.exp_end) begin
                chk("busy_stallreq", stallreq, 1);
                chk("busy_bus_err", bus_err, 0);
                chk("busy_cpu_data", cpu_data, 0);
            end else begin
                if (t.exp_kind != 2) chk("end_stallreq", stallreq, 0);
                chk("end_bus_err", bus_err, (t.exp_kind == 1) ? 1 : 0);
                chk("end_cpu_data", cpu_data, t.exp_data);
            end
            step();
            if (i == t.exp_end && t.exp_kind == 1) m_err_addr = t.addr;
        end
        wb_ack = 1'b0; wb_err = 1'b0; flush = 1'b0;
        if (t.exp_kind != 2) begin
            for (int j = 0; j < t.hold; j++) begin
                stall = (j < t.hold - 1) ? sv : '0;
                wb_ack = 1'($urandom);
                wb_err = 1'($urandom);
                @(negedge clk);
                chk("hold_cpu_data", cpu_data, t.exp_data);
                chk("hold_stallreq", stallreq, 0);
                chk("hold_cyc", wb_cyc, 0);
                chk("hold_bus_err", bus_err, 0);
                step();
            end
        end
        stall = '0; ce = 1'b1; flush = 1'b1; wb_ack = 1'($urandom); wb_err = 1'($urandom);
        @(negedge clk);
        chk("gap_stallreq", stallreq, 0);
        chk("gap_cyc", wb_cyc, 0);
        chk("gap_cpu_data", cpu_data, 0);
        chk("gap_bus_err", bus_err, 0);
        chk("gap_err_addr", bus_err_addr, m_err_addr);
        step();
        ce = 1'b0; flush = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        @(negedge clk);
        chk("gap_no_accept_cyc", wb_cyc, 0);
        chk("gap_idle_stallreq", stallreq, 0);
        step();
        $display("txn %0d: we=%0b addr=%h resp=%0d err=%0b flush_at=%0d hold=%0d -> kind=%0d end=%0d",
                 idx, t.we, t.addr, t.resp, t.err, t.flush_at, t.hold, t.exp_kind, t.exp_end);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cyc"}, wb_cyc, 0);
        chk({tag, "_stb"}, wb_stb, 0);
        chk({tag, "_addr"}, wb_addr, 0);
        chk({tag, "_wdata"}, wb_wdata, 0);
        chk({tag, "_we"}, wb_we, 0);
        chk({tag, "_sel"}, wb_sel, 0);
        chk({tag, "_cpu_data"}, cpu_data, 0);
        chk({tag, "_stallreq"}, stallreq, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_err_addr"}, bus_err_addr, 0);
    endtask

    initial begin
        txn_t t;
        rst = 1'b0; ce = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0;
        flush = 1'b0; stall = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
        m_err_addr = '0;
        step();
        step();
        @(negedge clk);
        chk_all_zero("reset");
        step();
        rst = 1'b1;

        //                 we  addr          sel    wdata     rdata                   resp  err  flush hold  end kind data
        table_q.push_back(mk(0, 32'h0000_0100, 8'hFF, 64'h0,    64'hDEAD_BEEF,          0,    0, NONE, 0,   0,  0,  64'hDEAD_BEEF));
        table_q.push_back(mk(0, 32'h0000_0200, 8'hFF, 64'h0,    64'h1234_5678,          1,    0, NONE, 3,   1,  0,  64'h1234_5678));
        table_q.push_back(mk(0, 32'h0000_0300, 8'h0F, 64'h0,    64'hAAAA_AAAA,          1,    0, 1,    0,   1,  2,  64'h0));
        table_q.push_back(mk(1, 32'h8000_0000, 8'hFF, 64'h55,   64'h7777,               0,    1, NONE, 0,   0,  1,  64'h0));
        table_q.push_back(mk(0, 32'h0000_4000, 8'hFF, 64'h0,    64'h9999,               NONE, 0, NONE, 0,   4,  1,  64'h0));
        table_q.push_back(mk(0, 32'h0000_0500, 8'hF0, 64'h0,    64'h0123_4567_89AB_CDEF, 2,   0, NONE, 0,   2,  0,  64'h0123_4567_89AB_CDEF));
        table_q.push_back(mk(1, 32'h0000_0600, 8'h3C, 64'hFEED_F00D_0BAD_CAFE, 64'h1111, 0, 0, NONE, 2,   0,  0,  64'h0));
        table_q.push_back(mk(0, 32'h0000_0700, 8'hFF, 64'h0,    64'h2222,               4,    0, NONE, 0,   4,  1,  64'h0));
        table_q.push_back(mk(0, 32'h0000_0800, 8'hFF, 64'h0,    64'h3333_4444_5555_6666, 3,   0, NONE, 1,   3,  0,  64'h3333_4444_5555_6666));
        table_q.push_back(mk(0, 32'h0000_0900, 8'hFF, 64'h0,    64'h4444,               2,    1, NONE, 2,   2,  1,  64'h0));
        table_q.push_back(mk(0, 32'h0000_0A00, 8'hFF, 64'h0,    64'h5555,               2,    1, 2,    0,   2,  2,  64'h0));
        foreach (table_q[k]) run_txn(table_q[k], k);

        for (int k = 0; k < 40; k++) begin
            t = mk(1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 5) == 0) ? NONE : int'($urandom_range(0, 6)),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : NONE,
                   int'($urandom_range(0, 3)), 0, 0, '0);
            predict(t);
            run_txn(t, 100 + k);
        end

        // Reset asserted while BUSY, with a simultaneous err/ack that must not pulse bus_err_o.
        ce = 1'b1; we = 1'b0; addr = 32'hCAFE_0000; sel = 8'hFF; wdata = 64'h0;
        @(negedge clk);
        step();
        ce = 1'b0;
        @(negedge clk);
        chk("rst_pre_cyc", wb_cyc, 1);
        step();
        rst = 1'b0; wb_err = 1'b1; wb_ack = 1'b1;
        @(negedge clk);
        chk("rst_cycle_bus_err", bus_err, 0);
        chk("rst_cycle_stallreq", stallreq, 0);
        step();
        rst = 1'b1; wb_err = 1'b0; wb_ack = 1'b0;
        m_err_addr = '0;
        @(negedge clk);
        chk_all_zero("rst_busy");
        step();
        $display("txn reset-while-busy: addr=%h", 32'hCAFE_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

Parametrised Wishbone classic-cycle master adapter between one CPU pipeline port (instruction fetch or data memory stage) and a Wishbone bus. It is the successor to the fixed 32-bit pipeline bus interface. New over that interface: configurable data and address widths, a selectable stall-vector bit, bus error input, a watchdog timeout, and a captured fault address. The core instantiates it twice, once for the fetch port and once for the memory port, with `ctrl` supplying `stall_i` and `flush_i`.

## Interface
- `DW`, 32, data width; a multiple of 8.
- `AW`, 32, address width.
- `STALL_W`, 6, width of the pipeline stall vector.
- `STAGE`, 0, index of the stall bit that freezes the consuming stage.
- `TIMEOUT`, 255, maximum number of BUSY cycles before a forced error; 0 disables the watchdog.
- `clk  in  1`: the only clock.
- `rst  in  1`: reset, synchronous, active-low.
- `stall_i  in  STALL_W`: pipeline stall vector.
- `flush_i  in  1`: pipeline flush.
- `cpu_ce_i  in  1`: access request.
- `cpu_we_i  in  1`: write when 1.
- `cpu_sel_i  in  DW/8`: byte selects.
- `cpu_addr_i  in  AW`: access address.
- `cpu_data_i  in  DW`: write data.
- `cpu_data_o  out  DW`: read data to the pipeline.
- `stallreq_o  out  1`: stall request to `ctrl`.
- `bus_err_o  out  1`: one-cycle error pulse.
- `bus_err_addr_o  out  AW`: address of the last faulted access.
- `wishbone_data_i  in  DW`, `wishbone_ack_i  in  1`, `wishbone_err_i  in  1`: bus responses.
- `wishbone_addr_o  out  AW`, `wishbone_data_o  out  DW`, `wishbone_we_o  out  1`, `wishbone_sel_o  out  DW/8`, `wishbone_stb_o  out  1`, `wishbone_cyc_o  out  1`: bus request.

## Operation
- State machine: IDLE, BUSY, HOLD.
- **IDLE**
  - On `cpu_ce_i && !flush_i`: register addr/data/we/sel onto the bus, assert cyc and stb, clear the timeout counter, go to BUSY.
  - `stallreq_o` follows `cpu_ce_i && !flush_i` combinationally.
- **BUSY**
  - `stallreq_o` = 1 until a terminating event.
  - Terminating events, in priority order: flush, err, timeout, ack.
  - flush: drop cyc and stb, go to IDLE. No data returned, no error pulse.
  - err, or counter == TIMEOUT (TIMEOUT > 0):
    - drop cyc and stb;
    - `bus_err_o` = 1 for one cycle; `bus_err_addr_o` ← `wishbone_addr_o`;
    - read buffer ← 0.
  - ack: drop cyc and stb; read buffer ← `wishbone_data_i`.
  - After an err, timeout or ack:
    - `stallreq_o` = 0 in the same cycle;
    - `cpu_data_o` = `wishbone_data_i` (ack) or 0 (err) combinationally.
    - If `stall_i != 0`, go to HOLD; otherwise go to IDLE.
- **HOLD**
  - `cpu_data_o` = read buffer; `stallreq_o` = 0.
  - Go to IDLE when `stall_i == 0` or `flush_i`.
- In IDLE outside a completing cycle, `cpu_data_o` = 0.
- The watchdog counter is `$clog2(TIMEOUT+1)` bits. It saturates and never wraps.
- Writes return no data; `cpu_data_o` = 0.

## Timing
- Reset values:
  - all `wishbone_*_o` = 0;
  - state IDLE;
  - `cpu_data_o` = 0, `stallreq_o` = 0;
  - `bus_err_o` = 0, `bus_err_addr_o` = 0;
  - read buffer and counter = 0.
- Reset is sampled only on a `clk` edge. Reset asserted mid-transaction drops cyc at the next edge without an error pulse.
- Latency: request seen in cycle N, cyc/stb high from N+1; ack at cycle N+k, data visible to the pipeline at N+k, cyc low at N+k+1.
- Minimum read with a zero-wait-state slave: 2 cycles.
- Back-to-back accesses: a new request is accepted only in IDLE, so accesses are spaced at least 1 cycle apart (cyc low for at least one cycle).
- ack and err together: err wins. ack or err together with flush: flush wins.
- ack or err arriving outside BUSY is ignored.

## Structure
- Shared package `wb_pkg` holds:
  - the state enum (WB_IDLE, WB_BUSY, WB_HOLD);
  - the reset-active level constant;
  - the zero-word constant.
- One sub-module, `wb_watchdog`: a saturating counter with clear and enable that outputs `expired`. It is instantiated only when TIMEOUT > 0 (generate).
- The top-level core wires `stall_i` from `ctrl`, and ORs the `bus_err_o` outputs into the exception path.

## Test plan
- Zero-wait read: ce, addr 0x0000_0100; slave acks in the first BUSY cycle with 0xDEAD_BEEF. Expect `cpu_data_o` = 0xDEAD_BEEF in the ack cycle, stallreq low in that cycle, cyc high exactly 1 cycle.
- Stalled read: ack of 0x1234_5678 while `stall_i` = 6'b000011 for 3 cycles. Expect HOLD for 3 cycles, `cpu_data_o` = 0x1234_5678 throughout, then IDLE.
- Flush mid-transaction: flush in the 2nd BUSY cycle, with ack in the same cycle. Expect cyc low next cycle, no data, `bus_err_o` = 0.
- Error: write to 0x8000_0000 with err and ack asserted together. Expect one-cycle `bus_err_o`, `bus_err_addr_o` = 0x8000_0000, `cpu_data_o` = 0.
- Timeout with TIMEOUT = 4: slave never responds. Expect `bus_err_o` on the 5th BUSY cycle, cyc dropped the next cycle.
- Width: DW = 64. An 8-bit sel of 0xF0 passes unchanged and 64-bit read data returns intact. Reset asserted while BUSY leaves all outputs 0 after the next edge.
